// File: rtl/ksa_shuffle_s_mem_if.sv
// ---------------------------------------------------------------------------
// ksa_shuffle_s_mem_if
// Bundles the S-memory bus and the start/done handshake of the RC4 key
// scheduling shuffle stage.
//   start              : begin shuffle (master FSM -> shuffle)
//   shuffle_done       : sticky completion flag (shuffle -> master FSM)
//   s_address_out      : S memory address (shuffle -> memory)
//   s_data_out         : S memory write data (shuffle -> memory)
//   s_write_enable_out : S memory write strobe (shuffle -> memory)
//   s_data_in          : S memory read data (memory -> shuffle)
// master modport: the shuffle engine. slave modport: memory / master FSM side.
// ---------------------------------------------------------------------------
interface ksa_shuffle_s_mem_if;
    logic       start;
    logic       shuffle_done;
    logic [7:0] s_address_out;
    logic [7:0] s_data_out;
    logic       s_write_enable_out;
    logic [7:0] s_data_in;

    modport master (
        input  start,
        input  s_data_in,
        output shuffle_done,
        output s_address_out,
        output s_data_out,
        output s_write_enable_out
    );

    modport slave (
        output start,
        output s_data_in,
        input  shuffle_done,
        input  s_address_out,
        input  s_data_out,
        input  s_write_enable_out
    );
endinterface

// File: rtl/ksa_shuffle_s_mem.sv
// ---------------------------------------------------------------------------
// ksa_shuffle_s_mem
// RC4 key-scheduling shuffle. Starting from an identity-filled S memory it
// walks i = 0..255, accumulates j = j + s[i] + key[i mod KEY_BYTES] and swaps
// s[i] with s[j] through a single-port synchronous-read S memory. A sticky
// shuffle_done flag is raised when all 256 iterations have completed.
//
// Parameters:
//   KEY_BYTES   : key length in bytes (1..32)
// Ports:
//   clk         : system clock, rising edge
//   reset       : asynchronous active-low reset
//   secret_key  : key, byte 0 in the most significant byte
//   bus         : ksa_shuffle_s_mem_if.master (start/done + S memory bus)
// Build option:
//   KSA_SELF_SWAP_SKIP_EN : when defined, an iteration whose new j equals i
//   skips the read of s[j] and both writes (4 cycles instead of 9). Final S
//   contents are identical either way.
//
// All bus outputs are registered: they are decoded from the next state and
// next register values, so they change on the same edge as the state.
// ---------------------------------------------------------------------------
module ksa_shuffle_s_mem #(
    parameter int KEY_BYTES = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [8*KEY_BYTES-1:0] secret_key,
    ksa_shuffle_s_mem_if.master    bus
);

    localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_RD_I   = 4'd1,
        ST_WT_I   = 4'd2,
        ST_LD_I   = 4'd3,
        ST_RD_J   = 4'd4,
        ST_WT_J   = 4'd5,
        ST_LD_J   = 4'd6,
        ST_WR_I   = 4'd7,
        ST_WR_J   = 4'd8,
        ST_NEXT   = 4'd9,
        ST_FINISH = 4'd10
    } state_t;

    state_t        state_r;
    state_t        state_nxt_s;
    logic [8:0]    i_r;
    logic [8:0]    i_nxt_s;
    logic [7:0]    j_r;
    logic [7:0]    j_nxt_s;
    logic [KW-1:0] k_r;
    logic [KW-1:0] k_nxt_s;
    logic [7:0]    si_r;
    logic [7:0]    si_nxt_s;
    logic [7:0]    sj_r;
    logic [7:0]    sj_nxt_s;

    logic [7:0]    key_byte_s;
    logic [7:0]    j_sum_s;

    logic [7:0]    addr_r;
    logic [7:0]    addr_nxt_s;
    logic [7:0]    data_r;
    logic [7:0]    data_nxt_s;
    logic          we_r;
    logic          we_nxt_s;
    logic          done_r;
    logic          done_nxt_s;

    // Key byte selected by k; OR-merge of one-hot masked bytes avoids an
    // out-of-range array index when KEY_BYTES is not a power of two.
    always_comb begin
        key_byte_s = 8'h00;
        for (int b = 0; b < KEY_BYTES; b++) begin
            key_byte_s = key_byte_s |
                         ((k_r == KW'(b)) ? secret_key[8*(KEY_BYTES-1-b) +: 8] : 8'h00);
        end
    end

    // Running j accumulation, 8-bit with silent wrap.
    always_comb begin
        j_sum_s = j_r + bus.s_data_in + key_byte_s;
    end

    // Next-state and next register values for the shuffle sequencer.
    always_comb begin
        state_nxt_s = state_r;
        i_nxt_s     = i_r;
        j_nxt_s     = j_r;
        k_nxt_s     = k_r;
        si_nxt_s    = si_r;
        sj_nxt_s    = sj_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_nxt_s = ST_RD_I;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RD_I: state_nxt_s = ST_WT_I;
            ST_WT_I: state_nxt_s = ST_LD_I;
            ST_LD_I: begin
                si_nxt_s = bus.s_data_in;
                j_nxt_s  = j_sum_s;
`ifdef KSA_SELF_SWAP_SKIP_EN
                // A self-swap leaves S unchanged, so skip straight to NEXT.
                if (j_sum_s == i_r[7:0]) begin
                    state_nxt_s = ST_NEXT;
                end else begin
                    state_nxt_s = ST_RD_J;
                end
`else
                state_nxt_s = ST_RD_J;
`endif
            end
            ST_RD_J: state_nxt_s = ST_WT_J;
            ST_WT_J: state_nxt_s = ST_LD_J;
            ST_LD_J: begin
                sj_nxt_s    = bus.s_data_in;
                state_nxt_s = ST_WR_I;
            end
            ST_WR_I: state_nxt_s = ST_WR_J;
            ST_WR_J: state_nxt_s = ST_NEXT;
            ST_NEXT: begin
                i_nxt_s = i_r + 9'd1;
                if (k_r == KW'(KEY_BYTES - 1)) begin
                    k_nxt_s = '0;
                end else begin
                    k_nxt_s = k_r + KW'(1);
                end
                if (i_r == 9'd255) begin
                    state_nxt_s = ST_FINISH;
                end else begin
                    state_nxt_s = ST_RD_I;
                end
            end
            ST_FINISH: state_nxt_s = ST_FINISH;
            default:   state_nxt_s = ST_IDLE;
        endcase
    end

    // Output decode from the upcoming state so the bus registers line up
    // with the state they describe.
    always_comb begin
        addr_nxt_s = 8'h00;
        data_nxt_s = 8'h00;
        we_nxt_s   = 1'b0;
        done_nxt_s = 1'b0;
        case (state_nxt_s)
            ST_RD_I, ST_WT_I, ST_LD_I: addr_nxt_s = i_nxt_s[7:0];
            ST_RD_J, ST_WT_J, ST_LD_J: addr_nxt_s = j_nxt_s;
            ST_WR_I: begin
                addr_nxt_s = i_nxt_s[7:0];
                data_nxt_s = sj_nxt_s;
                we_nxt_s   = 1'b1;
            end
            ST_WR_J: begin
                addr_nxt_s = j_nxt_s;
                data_nxt_s = si_nxt_s;
                we_nxt_s   = 1'b1;
            end
            ST_FINISH: done_nxt_s = 1'b1;
            default: begin
                addr_nxt_s = 8'h00;
                data_nxt_s = 8'h00;
                we_nxt_s   = 1'b0;
                done_nxt_s = 1'b0;
            end
        endcase
    end

    // State, datapath and registered bus outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            i_r     <= 9'd0;
            j_r     <= 8'd0;
            k_r     <= '0;
            si_r    <= 8'd0;
            sj_r    <= 8'd0;
            addr_r  <= 8'd0;
            data_r  <= 8'd0;
            we_r    <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            i_r     <= i_nxt_s;
            j_r     <= j_nxt_s;
            k_r     <= k_nxt_s;
            si_r    <= si_nxt_s;
            sj_r    <= sj_nxt_s;
            addr_r  <= addr_nxt_s;
            data_r  <= data_nxt_s;
            we_r    <= we_nxt_s;
            done_r  <= done_nxt_s;
        end
    end

    assign bus.s_address_out      = addr_r;
    assign bus.s_data_out         = data_r;
    assign bus.s_write_enable_out = we_r;
    assign bus.shuffle_done       = done_r;

endmodule

// File: tb/tb_ksa_shuffle_s_mem.sv
// ---------------------------------------------------------------------------
// tb_ksa_shuffle_s_mem
// Two DUTs (KEY_BYTES=3 and KEY_BYTES=1), each on its own behavioural
// synchronous-read S memory. A software RC4 KSA model produces the expected
// write stream, the final S contents and the expected cycle count.
// ---------------------------------------------------------------------------
module tb_ksa_shuffle_s_mem;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [23:0] key0;
    logic [7:0]  key1;
    logic        start_s [2];
    logic [7:0]  rd_r    [2];
    logic [7:0]  addr_s  [2];
    logic [7:0]  data_s  [2];
    logic        we_s    [2];
    logic        done_s  [2];

    ksa_shuffle_s_mem_if bus0 ();
    ksa_shuffle_s_mem_if bus1 ();

    assign bus0.start     = start_s[0];
    assign bus0.s_data_in = rd_r[0];
    assign bus1.start     = start_s[1];
    assign bus1.s_data_in = rd_r[1];
    assign addr_s[0] = bus0.s_address_out;
    assign data_s[0] = bus0.s_data_out;
    assign we_s[0]   = bus0.s_write_enable_out;
    assign done_s[0] = bus0.shuffle_done;
    assign addr_s[1] = bus1.s_address_out;
    assign data_s[1] = bus1.s_data_out;
    assign we_s[1]   = bus1.s_write_enable_out;
    assign done_s[1] = bus1.shuffle_done;

    ksa_shuffle_s_mem #(.KEY_BYTES(3)) dut0 (
        .clk        (clk),
        .reset      (rst_n),
        .secret_key (key0),
        .bus        (bus0)
    );

    ksa_shuffle_s_mem #(.KEY_BYTES(1)) dut1 (
        .clk        (clk),
        .reset      (rst_n),
        .secret_key (key1),
        .bus        (bus1)
    );

    // Behavioural S memories: refilled with identity while reset is low.
    logic [7:0] mem [2][256];
    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (!rst_n) begin
                for (int a = 0; a < 256; a++) mem[u][a] <= 8'(a);
                rd_r[u] <= 8'h00;
            end else begin
                rd_r[u] <= mem[u][addr_s[u]];
                if (we_s[u]) mem[u][addr_s[u]] <= data_s[u];
            end
        end
    end

    int checks = 0;
    int errors = 0;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

`ifdef KSA_SELF_SWAP_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    typedef struct packed {
        logic [8:0] iter;
        logic [7:0] addr;
        logic [7:0] data;
        logic       is_i;
    } wr_t;

    wr_t        exp_q [2][$];
    logic [7:0] gold  [2][256];
    int         nself [2];
    logic [7:0] jlog  [256];
    logic [7:0] snap  [4];
    logic [7:0] kb    [32];
    int         klen;

    // Software RC4 KSA: expected write stream, final S, self-swap count.
    task automatic build(input int u);
        logic [7:0] s [256];
        logic [7:0] j;
        logic [7:0] t;
        wr_t        e;
        for (int a = 0; a < 256; a++) s[a] = 8'(a);
        j = 8'd0;
        nself[u] = 0;
        for (int i = 0; i < 256; i++) begin
            j = j + s[i] + kb[i % klen];
            jlog[i] = j;
            if (j == 8'(i)) nself[u]++;
            if (!(SKIP && j == 8'(i))) begin
                e.iter = 9'(i); e.addr = 8'(i); e.data = s[j]; e.is_i = 1'b1;
                exp_q[u].push_back(e);
                e.addr = j; e.data = s[i]; e.is_i = 1'b0;
                exp_q[u].push_back(e);
            end
            t = s[i]; s[i] = s[j]; s[j] = t;
            if (i == 2) for (int a = 0; a < 4; a++) snap[a] = s[a];
        end
        gold[u] = s;
    endtask

    int         pop_cnt    [2];
    int         low_run    [2];
    logic [8:0] last_iter  [2];
    logic       last_is_i  [2];
    logic [7:0] first_addr [2];
    logic [7:0] first_data [2];

    // Per-cycle compare: every write strobe against the model stream, write
    // spacing, and quiet outputs once finished.
    always @(negedge clk) begin
        wr_t e;
        for (int u = 0; u < 2; u++) begin
            if (!rst_n) begin
                exp_q[u].delete();
                pop_cnt[u] = 0;
                low_run[u] = 100;
                last_iter[u] = 9'd0;
                last_is_i[u] = 1'b0;
            end else begin
                if (we_s[u]) begin
                    if (low_run[u] != 0) chk($sformatf("u%0d_wr_gap", u), int'(low_run[u] >= 7), 1);
                    low_run[u] = 0;
                    chk($sformatf("u%0d_wr_expected", u), int'(exp_q[u].size() != 0), 1);
                    if (exp_q[u].size() != 0) begin
                        e = exp_q[u].pop_front();
                        if (pop_cnt[u] == 0) begin
                            first_addr[u] = addr_s[u];
                            first_data[u] = data_s[u];
                        end
                        pop_cnt[u]++;
                        last_iter[u] = e.iter;
                        last_is_i[u] = e.is_i;
                        chk($sformatf("u%0d_it%0d_addr", u, e.iter), int'(addr_s[u]), int'(e.addr));
                        chk($sformatf("u%0d_it%0d_data", u, e.iter), int'(data_s[u]), int'(e.data));
                    end
                end else begin
                    low_run[u]++;
                end
                if (done_s[u]) begin
                    chk($sformatf("u%0d_finish_outs", u),
                        int'({addr_s[u], data_s[u], we_s[u]}), 0);
                end
            end
        end
    end

    task automatic set_key(input int u, input logic [23:0] k);
        if (u == 0) begin
            key0 = k;
            kb[0] = k[23:16]; kb[1] = k[15:8]; kb[2] = k[7:0];
            klen = 3;
        end else begin
            key1 = k[7:0];
            kb[0] = k[7:0];
            klen = 1;
        end
    endtask

    // One complete shuffle run. mode 0: start pulsed then random re-pulses;
    // mode 1: start held high throughout.
    task automatic do_run(input int u, input int mode, input string name);
        int   cyc;
        bit   seen;
        int   diffs;
        int   missing;
        bit   present [256];
        rst_n = 1'b0;
        start_s[0] = 1'b0;
        start_s[1] = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        build(u);
        start_s[u] = 1'b1;
        @(negedge clk);
        cyc = 0;
        seen = 1'b0;
        for (int c = 0; c < 6000; c++) begin
            if (done_s[u]) begin
                seen = 1'b1;
                break;
            end
            cyc++;
            if (mode == 0) start_s[u] = ($urandom_range(0, 15) == 0);
            @(negedge clk);
        end
        chk({name, "_done_seen"}, int'(seen), 1);
        chk({name, "_cycles"}, cyc, SKIP ? 2304 - 5 * nself[u] : 2304);
        chk({name, "_writes"}, pop_cnt[u], SKIP ? 512 - 2 * nself[u] : 512);
        chk({name, "_leftover"}, exp_q[u].size(), 0);
        for (int c = 0; c < 100; c++) begin
            if (c == 50) start_s[u] = 1'b1;
            @(negedge clk);
            chk({name, "_done_sticky"}, int'(done_s[u]), 1);
        end
        start_s[u] = 1'b0;
        diffs = 0;
        missing = 0;
        for (int a = 0; a < 256; a++) present[a] = 1'b0;
        for (int a = 0; a < 256; a++) begin
            if (mem[u][a] != gold[u][a]) diffs++;
            present[mem[u][a]] = 1'b1;
        end
        for (int a = 0; a < 256; a++) if (!present[a]) missing++;
        chk({name, "_final_s_diffs"}, diffs, 0);
        chk({name, "_perm_missing"}, missing, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit hit;
        rst_n = 1'b0;
        start_s[0] = 1'b0;
        start_s[1] = 1'b0;
        key0 = 24'h000000;
        key1 = 8'h00;
        klen = 1;
        for (int a = 0; a < 32; a++) kb[a] = 8'h00;
        repeat (2) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            chk($sformatf("u%0d_reset_outs", u),
                int'({addr_s[u], data_s[u], we_s[u], done_s[u]}), 0);
        end

        // Zero key: model pinned with hand-computed values.
        set_key(0, 24'h000000);
        do_run(0, 0, "k000000");
        chk("pin_j_i0", int'(jlog[0]), 0);
        chk("pin_j_i1", int'(jlog[1]), 1);
        chk("pin_j_i2", int'(jlog[2]), 3);
        chk("pin_s2_after_i2", int'(snap[2]), 3);
        chk("pin_s3_after_i2", int'(snap[3]), 2);
        chk("k000000_first_wr_addr", int'(first_addr[0]), SKIP ? 2 : 0);
        chk("k000000_first_wr_data", int'(first_data[0]), SKIP ? 3 : 0);

        set_key(0, 24'h4A4B4C);
        do_run(0, 1, "k4a4b4c");

        for (int r = 0; r < 3; r++) begin
            set_key(0, 24'($urandom));
            do_run(0, r % 2, $sformatf("rand%0d", r));
        end

        // Reset asserted mid-write of iteration 100, then a clean rerun.
        set_key(0, 24'h000000);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        build(0);
        start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            #1;
            if (we_s[0] && last_is_i[0] && last_iter[0] >= 9'd100) begin
                hit = 1'b1;
                break;
            end
        end
        chk("rst_mid_hit", int'(hit), 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outs", int'({addr_s[0], data_s[0], we_s[0], done_s[0]}), 0);
        do_run(0, 0, "after_reset");

        set_key(1, 24'h0000FF);
        do_run(1, 0, "kb1_ff");
        set_key(1, 24'($urandom_range(0, 255)));
        do_run(1, 1, "kb1_rand");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
